dpdm_seq_ctrl: RTL
==================

Name: dpdm_seq_ctrl

Overview:
Control-word sequencer that drives the DP_DM datapath/data-memory block. It issues one control word per clock for a fixed 8-step routine, C = 2 - N + A - N, where N and A are loaded from data memory. It samples the DP_DM flags and RS1_out to report the sign and value of the result. It sits in front of DP_DM in place of hand-driven control and is the stepping stone to the full single-cycle control unit.

Parameters:
N_ADDR, 32'd0, data-memory address of operand N (driven on IMM during the N load)
A_ADDR, 32'd1, data-memory address of operand A (driven on IMM during the A load)
REG_C, 5'd1, register index holding C
REG_N, 5'd2, register index holding N
REG_A, 5'd3, register index holding A

Ports:
clk  in  1  clock, rising edge
reset  in  1  asynchronous, active-low reset
start  in  1  begin routine; sampled only in IDLE
V, C, N, Z, L  in  1 each  DP_DM ALU flags, combinational on the current control word
RS1_out  in  32  DP_DM register-file port-1 read data
RD, RS1, RS2  out  5 each  register addresses to DP_DM
FS  out  4  ALU function: 4'b0000 add, 4'b1000 sub
STRB  out  4  byte strobe, always 4'b1111
IMM  out  32  immediate / memory address
PC  out  32  constant 32'd0
MD, MB, RW, MP, MW  out  1 each  DP_DM mux and write controls
busy  out  1  high in every state except IDLE and DONE
done  out  1  one-cycle pulse when the result is valid
res_neg, res_zero, res_pos  out  1 each  sign of the final C, registered
result  out  32  final C, registered

Behaviour:
- Moore FSM with states IDLE, SET1, DBL, LDN, SUBN1, LDA, ADDA, SUBN2, RDC, DONE. Control outputs decode from the state only.
- Idle word, used in IDLE and DONE: RD=RS1=RS2=0, FS=0000, IMM=0, MD=MB=RW=MP=MW=0, STRB=1111, PC=0. No register or memory write occurs.
- SET1: RD=REG_C, RS1=0, MB=1, IMM=1, RW=1, FS=add. Result: C=1.
- DBL: RD=RS1=RS2=REG_C, MB=0, RW=1, FS=add. Result: C=2.
- LDN: RD=REG_N, RS1=0, MB=1, MD=1, IMM=N_ADDR, RW=1. Result: N loaded from memory.
- SUBN1: RD=REG_C, RS1=REG_C, RS2=REG_N, MB=0, RW=1, FS=sub.
- LDA: as LDN, but with RD=REG_A and IMM=A_ADDR.
- ADDA: RD=REG_C, RS1=REG_C, RS2=REG_A, RW=1, FS=add.
- SUBN2: as SUBN1.
- RDC: RW=0, RS1=REG_C. No write occurs.
- Transitions: IDLE->SET1 on clk edge with start=1. Each routine state advances unconditionally, one state per clock, RDC->DONE, DONE->IDLE.
- Latency: start sampled at edge 0 gives SET1 in cycle 1, SUBN2 in cycle 7, RDC in cycle 8, and done=1 in cycle 9 only.
- At the edge leaving SUBN2, the flags are captured:
  - res_neg <= N
  - res_zero <= Z
  - res_pos <= ~N & ~Z
- At the edge leaving RDC, result <= RS1_out.
- Arithmetic is 32-bit two's complement, wrapping on overflow. V is ignored for classification.
- start is ignored while busy or in DONE. A start held high re-triggers on the edge leaving IDLE after DONE.
- Reset (asynchronous, active-low) forces IDLE and clears result, res_neg, res_zero, res_pos and done. The idle word is driven immediately.
- Reset mid-routine aborts the routine. Registers already written in DP_DM keep their values, and the next start reruns from SET1.
- Outputs hold their last result until the next completed routine. They are not cleared by start.

Test Plan:
- Reset low, then high with start=0 for 5 cycles -> RW=0, MW=0, busy=0, done=0, result=0 throughout.
- mem[0]=1, mem[1]=1, pulse start -> busy for cycles 1-8, done in cycle 9, result=1, res_pos=1, res_neg=0, res_zero=0.
- mem[0]=3, mem[1]=1 -> result=32'hFFFFFFFD, res_neg=1.
- mem[0]=4, mem[1]=6 -> result=0, res_zero=1, res_neg=0.
- Assert reset low during ADDA, release, then start with mem[0]=1, mem[1]=1 -> full 9-cycle run, result=1, res_pos=1.
- Pulse start again while busy in cycle 4 -> no restart, done still in cycle 9. Hold start high -> back-to-back runs, each done pulse separated by one IDLE cycle.

Source files
------------

// File: rtl/dpdm_seq_ctrl.sv
// rtl/dpdm_seq_ctrl.sv - Fixed 8-step control-word sequencer for DP_DM computing C = 2 - N + A - N.
module dpdm_seq_ctrl #(
    parameter logic [31:0] N_ADDR = 32'd0,
    parameter logic [31:0] A_ADDR = 32'd1,
    parameter logic [4:0]  REG_C  = 5'd1,
    parameter logic [4:0]  REG_N  = 5'd2,
    parameter logic [4:0]  REG_A  = 5'd3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        V,
    input  logic        C,
    input  logic        N,
    input  logic        Z,
    input  logic        L,
    input  logic [31:0] RS1_out,
    output logic [4:0]  RD,
    output logic [4:0]  RS1,
    output logic [4:0]  RS2,
    output logic [3:0]  FS,
    output logic [3:0]  STRB,
    output logic [31:0] IMM,
    output logic [31:0] PC,
    output logic        MD,
    output logic        MB,
    output logic        RW,
    output logic        MP,
    output logic        MW,
    output logic        busy,
    output logic        done,
    output logic        res_neg,
    output logic        res_zero,
    output logic        res_pos,
    output logic [31:0] result
);

    typedef enum logic [3:0] {
        IDLE, SET1, DBL, LDN, SUBN1, LDA, ADDA, SUBN2, RDC, DONE
    } state_t;

    typedef struct packed {
        logic [4:0]  rd;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [3:0]  fs;
        logic [31:0] imm;
        logic        md;
        logic        mb;
        logic        rw;
    } word_t;

    localparam logic [3:0] FS_ADD = 4'b0000;
    localparam logic [3:0] FS_SUB = 4'b1000;

    // Overflow, carry and less-than play no part in classifying the result.
    logic unused_flags;
    assign unused_flags = V ^ C ^ L;

    assign STRB = 4'b1111;
    assign PC   = 32'd0;
    assign MP   = 1'b0;
    assign MW   = 1'b0;

    function automatic word_t word_of(input state_t s);
        word_t w;
        w = '0;
        case (s)
            SET1:  begin w.rd = REG_C; w.mb = 1'b1; w.imm = 32'd1; w.rw = 1'b1; w.fs = FS_ADD; end
            DBL:   begin w.rd = REG_C; w.rs1 = REG_C; w.rs2 = REG_C; w.rw = 1'b1; w.fs = FS_ADD; end
            LDN:   begin w.rd = REG_N; w.mb = 1'b1; w.md = 1'b1; w.imm = N_ADDR; w.rw = 1'b1; end
            SUBN1: begin w.rd = REG_C; w.rs1 = REG_C; w.rs2 = REG_N; w.rw = 1'b1; w.fs = FS_SUB; end
            LDA:   begin w.rd = REG_A; w.mb = 1'b1; w.md = 1'b1; w.imm = A_ADDR; w.rw = 1'b1; end
            ADDA:  begin w.rd = REG_C; w.rs1 = REG_C; w.rs2 = REG_A; w.rw = 1'b1; w.fs = FS_ADD; end
            SUBN2: begin w.rd = REG_C; w.rs1 = REG_C; w.rs2 = REG_N; w.rw = 1'b1; w.fs = FS_SUB; end
            RDC:   begin w.rs1 = REG_C; end
            default: w = '0;
        endcase
        return w;
    endfunction

    function automatic state_t next_of(input state_t s, input logic go);
        state_t n;
        case (s)
            IDLE:    n = go ? SET1 : IDLE;
            SET1:    n = DBL;
            DBL:     n = LDN;
            LDN:     n = SUBN1;
            SUBN1:   n = LDA;
            LDA:     n = ADDA;
            ADDA:    n = SUBN2;
            SUBN2:   n = RDC;
            RDC:     n = DONE;
            default: n = IDLE;
        endcase
        return n;
    endfunction

    state_t state;
    state_t state_nxt;
    word_t  word_nxt;

    always_comb begin
        state_nxt = next_of(state, start);
        word_nxt  = word_of(state_nxt);
    end

    // Outputs are registered from the next state's word so they line up with the state register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= IDLE;
            RD       <= '0;
            RS1      <= '0;
            RS2      <= '0;
            FS       <= '0;
            IMM      <= '0;
            MD       <= 1'b0;
            MB       <= 1'b0;
            RW       <= 1'b0;
            busy     <= 1'b0;
            done     <= 1'b0;
            res_neg  <= 1'b0;
            res_zero <= 1'b0;
            res_pos  <= 1'b0;
            result   <= '0;
        end else begin
            state <= state_nxt;
            RD    <= word_nxt.rd;
            RS1   <= word_nxt.rs1;
            RS2   <= word_nxt.rs2;
            FS    <= word_nxt.fs;
            IMM   <= word_nxt.imm;
            MD    <= word_nxt.md;
            MB    <= word_nxt.mb;
            RW    <= word_nxt.rw;
            busy  <= (state_nxt != IDLE) && (state_nxt != DONE);
            done  <= (state_nxt == DONE);
            if (state == SUBN2) begin
                res_neg  <= N;
                res_zero <= Z;
                res_pos  <= ~N & ~Z;
            end
            if (state == RDC) begin
                result <= RS1_out;
            end
        end
    end

endmodule
